// File: rtl/dbus_pkg.sv
// Shared types and default memory map for the data-bus arbiter.
package dbus_pkg;

    localparam int unsigned DBUS_DW          = 32;
    localparam int unsigned RAM_BASE_DEF     = 2944;
    localparam int unsigned RAM_WORDS_DEF    = 1024;
    localparam int unsigned EXT_TIMEOUT_DEF  = 15;
    localparam int unsigned TMO_W            = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_ACC  = 2'd1,
        EXT_WAIT = 2'd2,
        RESP     = 2'd3
    } dbus_state_e;

endpackage

// File: rtl/dbus_arbiter_rr.sv
// Two-way round-robin picker with its own last-grant register.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Pick the requester that did not win last time when both ask.
    always_comb begin
        gnt_valid  = |req;
        gnt_id     = (req == 2'b11) ? ~last_gnt_q : req[1];
        last_gnt_d = last_gnt_q;
        if (enable && gnt_valid) begin
            last_gnt_d = gnt_id;
        end
    end

    // Last-grant register; reset to M1 so M0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: shares local data RAM and the external bus between
// the pipeline memory stage (M0) and the DMA/debug loader (M1).
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned RAM_BASE    = RAM_BASE_DEF,
    parameter int unsigned RAM_WORDS   = RAM_WORDS_DEF,
    parameter int unsigned EXT_TIMEOUT = EXT_TIMEOUT_DEF,
    parameter int unsigned DW          = DBUS_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_done,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_done,
    output logic          m1_err,

    output logic [DW-1:0] rdata,
    output logic          gnt_id,
    output logic          busy,

    output logic          ram_wren,
    output logic [DW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q,

    output logic          ext_cs,
    output logic          ext_we,
    output logic [DW-1:0] ext_addr,
    output logic [DW-1:0] ext_wdata,
    input  logic [DW-1:0] ext_rdata,
    input  logic          ext_ack
);

    localparam logic [DW-1:0]    BASE_W  = DW'(RAM_BASE);
    localparam logic [DW-1:0]    WORDS_W = DW'(RAM_WORDS);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(EXT_TIMEOUT - 1);

    dbus_state_e state_q, state_d;

    // Latched transaction
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             id_q, id_d;
    logic             ram_sel_q, ram_sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DW-1:0]    ext_cap_q, ext_cap_d;
    logic             err_q, err_d;

    // Registered outputs
    logic             m0_done_q, m0_done_d;
    logic             m1_done_q, m1_done_d;
    logic             m0_err_q, m0_err_d;
    logic             m1_err_q, m1_err_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             ram_wren_q, ram_wren_d;
    logic [DW-1:0]    ram_addr_q, ram_addr_d;
    logic [DW-1:0]    ram_data_q, ram_data_d;
    logic             ext_cs_q, ext_cs_d;
    logic             ext_we_q, ext_we_d;
    logic [DW-1:0]    ext_addr_q, ext_addr_d;
    logic [DW-1:0]    ext_wdata_q, ext_wdata_d;

    // Arbitration and decode of the candidate request
    logic [1:0]       arb_req_c;
    logic             arb_valid_c;
    logic             arb_id_c;
    logic [DW-1:0]    sel_addr_c;
    logic [DW-1:0]    sel_off_c;
    logic             sel_in_ram_c;

    // A req still high during its own done cycle is the tail of the
    // finished transaction, so it is masked for that one cycle.
    always_comb begin
        arb_req_c = {m1_req & ~m1_done_q, m0_req & ~m0_done_q};
    end

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req_c),
        .enable    (state_q == IDLE),
        .gnt_valid (arb_valid_c),
        .gnt_id    (arb_id_c)
    );

    // Memory-map decode: unsigned window check via modular offset.
    always_comb begin
        sel_addr_c   = arb_id_c ? m1_addr : m0_addr;
        sel_off_c    = sel_addr_c - BASE_W;
        sel_in_ram_c = (sel_off_c < WORDS_W);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        id_d      = id_q;
        ram_sel_d = ram_sel_q;
        tmo_d     = tmo_q;
        ext_cap_d = ext_cap_q;
        err_d     = err_q;
        m0_done_d = 1'b0;
        m1_done_d = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        rdata_d   = rdata_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    id_d      = arb_id_c;
                    addr_d    = sel_addr_c;
                    we_d      = arb_id_c ? m1_we : m0_we;
                    wdata_d   = arb_id_c ? m1_wdata : m0_wdata;
                    ram_sel_d = sel_in_ram_c;
                    tmo_d     = '0;
                    err_d     = 1'b0;
                    ext_cap_d = '0;
                    busy_d    = 1'b1;
                    state_d   = sel_in_ram_c ? RAM_ACC : EXT_WAIT;
                end
            end
            RAM_ACC: begin
                state_d = RESP;
            end
            EXT_WAIT: begin
                // ack wins over a coincident timeout
                if (ext_ack) begin
                    ext_cap_d = ext_rdata;
                    err_d     = 1'b0;
                    state_d   = RESP;
                end else if (tmo_q == TMO_MAX) begin
                    ext_cap_d = '0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                m0_done_d = ~id_q;
                m1_done_d = id_q;
                m0_err_d  = ~id_q & err_q;
                m1_err_d  = id_q & err_q;
                if (err_q) begin
                    rdata_d = '0;
                end else if (!we_q) begin
                    rdata_d = ram_sel_q ? ram_q : ext_cap_q;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Datapath pins follow the state being entered next cycle.
        ram_wren_d  = (state_d == RAM_ACC) & we_d;
        ram_addr_d  = addr_d - BASE_W;
        ram_data_d  = wdata_d;
        ext_cs_d    = (state_d == EXT_WAIT);
        ext_we_d    = (state_d == EXT_WAIT) & we_d;
        ext_addr_d  = addr_d;
        ext_wdata_d = wdata_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            id_q        <= 1'b0;
            ram_sel_q   <= 1'b0;
            tmo_q       <= '0;
            ext_cap_q   <= '0;
            err_q       <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ext_cs_q    <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            id_q        <= id_d;
            ram_sel_q   <= ram_sel_d;
            tmo_q       <= tmo_d;
            ext_cap_q   <= ext_cap_d;
            err_q       <= err_d;
            m0_done_q   <= m0_done_d;
            m1_done_q   <= m1_done_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ram_wren_q  <= ram_wren_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ext_cs_q    <= ext_cs_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
        end
    end

    // Port mapping.
    always_comb begin
        m0_done   = m0_done_q;
        m1_done   = m1_done_q;
        m0_err    = m0_err_q;
        m1_err    = m1_err_q;
        rdata     = rdata_q;
        gnt_id    = id_q;
        busy      = busy_q;
        ram_wren  = ram_wren_q;
        ram_addr  = ram_addr_q;
        ram_data  = ram_data_q;
        ext_cs    = ext_cs_q;
        ext_we    = ext_we_q;
        ext_addr  = ext_addr_q;
        ext_wdata = ext_wdata_q;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-memory and external-bus port between two requesters: pipeline memory stage (M0) and a DMA/debug loader (M1).
- Performs round-robin arbitration and address decoding into local RAM versus external bus.
- Generates RAM wren, rebased RAM address, external CS/WE and the wait-state/timeout sequencing.
- Sits between the pipeline Memory stage and the datamemory / external data-bus pins.

Parameters:
- RAM_BASE, 2944: first byte address mapped to local data RAM.
- RAM_WORDS, 1024: size of local RAM window, in addresses.
- EXT_TIMEOUT, 15: maximum cycles to wait for ext_ack before aborting.
- DW, 32: data and address width.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  request; held high until the matching done.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  DW  byte address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with done; 1 = external timeout.
- rdata  out  DW  read result; valid in the done cycle, held until the next done.
- gnt_id  out  1  master currently owning the bus; valid while busy.
- busy  out  1  a transaction is in flight.
- ram_wren  out  1  data RAM write enable.
- ram_addr  out  DW  rebased address (addr - RAM_BASE).
- ram_data  out  DW  RAM write data.
- ram_q  in  DW  RAM read data; synchronous, 1-cycle latency.
- ext_cs, ext_we  out  1  external bus chip select / write enable.
- ext_addr, ext_wdata  out  DW  external address and write data (unrebased).
- ext_rdata  in  DW  external read data.
- ext_ack  in  1  external completion.

Behaviour:
- FSM states: IDLE, RAM_ACC, EXT_WAIT, RESP.
- IDLE
  - If any request is pending, select a master, latch its addr/we/wdata/id, and set busy.
  - Tie break: the master not granted last wins; after reset M0 has priority.
  - Decode: RAM_BASE <= addr < RAM_BASE+RAM_WORDS goes to RAM_ACC; anything else goes to EXT_WAIT. Compare is unsigned.
- RAM_ACC (exactly 1 cycle)
  - ram_addr = latched addr - RAM_BASE; ram_wren = we; ram_data = wdata.
  - Next state RESP.
- EXT_WAIT
  - ext_cs = 1; ext_we, ext_addr and ext_wdata held stable from latched values.
  - A 4-bit timeout counter starts at 0 and increments each cycle.
  - On ext_ack: capture ext_rdata, go to RESP, err = 0.
  - If counter reaches EXT_TIMEOUT-1 without ack: go to RESP, err = 1, rdata = 0.
  - ack in the same cycle as the timeout counts as success.
- RESP (1 cycle)
  - Pulse done for the owner; err as determined.
  - rdata = ram_q for RAM reads, captured external data for external reads; rdata is unchanged on writes.
  - Clear busy; next state IDLE. A new grant can be issued on the next cycle.
- Latency (req sampled to done)
  - RAM: 3 cycles.
  - External: 3 + wait cycles; max 2 + EXT_TIMEOUT.
- req deassertion mid-transaction is ignored; the transaction completes and done is still pulsed.
- The other master's req is queued, not dropped. Back-to-back requests from both masters alternate.
- Idle state of datapath outputs: ram_wren = 0, ext_cs = 0, ext_we = 0; address and data outputs are don't-care (driven with the latched values).
- Reset values (asynchronous, any state): state IDLE, all outputs 0, last grant = M1 (so M0 wins first), counter 0.
  - No done is pulsed for an aborted transaction.
  - ext_cs and ram_wren drop immediately on reset.
- Address arithmetic is DW-bit modular; no carry out.

Decomposition:
- Shared package dbus_pkg holds:
  - state enum (IDLE, RAM_ACC, EXT_WAIT, RESP)
  - RAM_BASE / RAM_WORDS defaults, also used by the memory-map decoder
  - EXT_TIMEOUT default
- One natural sub-module, rr_arbiter2: 2-way round-robin picker.
  - Inputs: req[1:0], last_gnt, enable.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational plus the last-grant register.
- Decode and FSM stay in dbus_arbiter.

Test Plan:
1. RAM read: after reset, M0 reads addr 2948 with RAM word 4 = 32'hDEADBEEF → ram_addr = 4 in RAM_ACC, m0_done on cycle 3, rdata = DEADBEEF, err = 0.
2. RAM write: M1 writes 32'h12345678 to 3000 → exactly one cycle of ram_wren = 1 with ram_addr = 56; m1_done on cycle 3; rdata unchanged.
3. Contention: M0 and M1 both request RAM reads continuously → grants M0, M1, M0, M1; each done 3 cycles apart; neither master is starved.
4. External with waits: M0 reads addr 100, ext_ack after 4 cycles with ext_rdata = 7 → ext_cs high 4 cycles, m0_done one cycle later, rdata = 7.
5. Timeout: M1 writes addr 0 and ext_ack is never asserted → ext_cs high 15 cycles, then m1_done = 1 with m1_err = 1, rdata = 0, busy = 0 next cycle.
6. Reset mid-transaction: assert RST during EXT_WAIT → ext_cs = 0 immediately, no done pulse. After release with both masters requesting, M0 is granted first.
